core_burst_ctrl: RTL

CORE_BURST_CTRL -- requirements
Module: core_burst_ctrl

---
 rtl/core_burst_ctrl_pkg.sv | 43 ++++
 rtl/core_burst_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/core_burst_ctrl_pkg.sv
//----------------------------------------------------------------------------
// Module      : core_burst_ctrl_pkg
// Description : Shared types and defaults for the core burst controller.
//               Provides the burst and control state encodings and the
//               default DRAIN watchdog length.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

`ifndef GBUS_DATA_WIDTH
`define GBUS_DATA_WIDTH 64
`endif
`ifndef GBUS_ADDR_WIDTH
`define GBUS_ADDR_WIDTH 12
`endif
`ifndef CDATA_ACCU_NUM_WIDTH
`define CDATA_ACCU_NUM_WIDTH 8
`endif

package core_burst_ctrl_pkg;

  // Burst sequencing: feed activations, wait for core outputs, report.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } BURST_STATE;

  // Top-level job control encoding shared with the rest of the codebase.
  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_LOAD  = 2'd1,
    CTRL_RUN   = 2'd2,
    CTRL_FLUSH = 2'd3
  } CONTROL_STATE;

  // Default number of DRAIN cycles before the watchdog gives up.
  localparam int DRAIN_TIMEOUT_DEFAULT = 1024;

endpackage

`default_nettype wire

// File: rtl/core_burst_ctrl.sv
//----------------------------------------------------------------------------
// Module      : core_burst_ctrl
// Description : Streams a burst of activation words from global SRAM onto a
//               core horizontal link, then waits for the expected number of
//               quantizer outputs and reports done/err.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

`ifndef GBUS_DATA_WIDTH
`define GBUS_DATA_WIDTH 64
`endif
`ifndef GBUS_ADDR_WIDTH
`define GBUS_ADDR_WIDTH 12
`endif
`ifndef CDATA_ACCU_NUM_WIDTH
`define CDATA_ACCU_NUM_WIDTH 8
`endif

module core_burst_ctrl
  import core_burst_ctrl_pkg::*;
#(
  parameter int GBUS_DATA_WIDTH      = `GBUS_DATA_WIDTH,
  parameter int GBUS_ADDR_WIDTH      = `GBUS_ADDR_WIDTH,
  parameter int CDATA_ACCU_NUM_WIDTH = `CDATA_ACCU_NUM_WIDTH,
  parameter int LEN_WIDTH            = 16,
  parameter int DRAIN_TIMEOUT        = DRAIN_TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [GBUS_ADDR_WIDTH-1:0]      cfg_in_base_addr,
  input  logic [LEN_WIDTH-1:0]            cfg_compute_len,
  input  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num,
  output logic                            sram_ren,
  output logic [GBUS_ADDR_WIDTH-1:0]      sram_raddr,
  input  logic [GBUS_DATA_WIDTH-1:0]      sram_rdata,
  output logic                            hlink_wen,
  output logic [GBUS_DATA_WIDTH-1:0]      hlink_wdata,
  input  logic                            quant_odata_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int c_tmo_w = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0]              c_tmo_last = c_tmo_w'(DRAIN_TIMEOUT - 1);
  localparam logic [c_tmo_w-1:0]              c_tmo_one  = c_tmo_w'(1);
  localparam logic [LEN_WIDTH-1:0]            c_len_one  = LEN_WIDTH'(1);
  localparam logic [CDATA_ACCU_NUM_WIDTH-1:0] c_acc_one  = CDATA_ACCU_NUM_WIDTH'(1);

  BURST_STATE                      r_state;
  BURST_STATE                      w_state_next;
  logic [GBUS_ADDR_WIDTH-1:0]      r_base;
  logic [LEN_WIDTH-1:0]            r_len;
  logic [CDATA_ACCU_NUM_WIDTH-1:0] r_acc_num;
  logic [LEN_WIDTH-1:0]            r_beat;
  logic [CDATA_ACCU_NUM_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0]            r_expected;
  logic [LEN_WIDTH-1:0]            r_received;
  logic [c_tmo_w-1:0]              r_drain_cnt;
  logic                            r_rd_pend;
  logic                            r_cfg_err;
  logic                            r_timeout;
  logic                            r_extra;

  logic                            w_cfg_ok;
  logic                            w_accept;
  logic                            w_issue;
  logic                            w_qv;
  logic [LEN_WIDTH-1:0]            w_rcv_next;
  logic                            w_drain_hit;
  logic                            w_tmo;
  logic                            w_extra_now;
  logic                            w_job_err;
  logic [GBUS_ADDR_WIDTH-1:0]      w_addr;

  assign w_cfg_ok    = (cfg_compute_len != '0) && (cfg_acc_num != '0);
  assign w_accept    = (r_state == IDLE) && start;
  // A read is issued for every beat index below len; FEED then lingers one
  // extra cycle so the last read's data reaches hlink before DRAIN.
  assign w_issue     = (r_state == FEED) && (r_beat != r_len);
  assign w_addr      = r_base + GBUS_ADDR_WIDTH'(r_beat);
  assign w_qv        = quant_odata_valid && (r_state != IDLE);
  assign w_rcv_next  = r_received + LEN_WIDTH'(w_qv);
  // Look at the post-increment count so done follows the final output by
  // exactly one cycle.
  assign w_drain_hit = (w_rcv_next == r_expected);
  assign w_tmo       = (r_drain_cnt == c_tmo_last);
  assign w_extra_now = w_qv && (r_received >= r_expected);
  // A leftover accumulation phase means the final group was partial.
  assign w_job_err   = (r_acc != '0) || r_timeout || r_extra || w_extra_now;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and output generation.
  always_comb begin
    w_state_next = r_state;
    sram_ren     = 1'b0;
    sram_raddr   = '0;
    hlink_wen    = r_rd_pend;
    hlink_wdata  = '0;
    busy         = (r_state != IDLE);
    done         = r_cfg_err;
    err          = r_cfg_err;
    case (r_state)
      IDLE:    if (start && w_cfg_ok) w_state_next = FEED;
      FEED:    if (r_beat == r_len) w_state_next = DRAIN;
      DRAIN:   if (w_drain_hit || w_tmo) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_issue) begin
      sram_ren   = 1'b1;
      sram_raddr = w_addr;
    end
    if (r_rd_pend) begin
      hlink_wdata = sram_rdata;
    end
    if (r_state == DONE) begin
      done = 1'b1;
      err  = w_job_err;
    end
  end

  // Configuration latch, beat/accumulation/output counters and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_acc_num   <= '0;
      r_beat      <= '0;
      r_acc       <= '0;
      r_expected  <= '0;
      r_received  <= '0;
      r_drain_cnt <= '0;
      r_rd_pend   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_timeout   <= 1'b0;
      r_extra     <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_cfg_err <= w_accept && !w_cfg_ok;
      if (w_accept && w_cfg_ok) begin
        r_base      <= cfg_in_base_addr;
        r_len       <= cfg_compute_len;
        r_acc_num   <= cfg_acc_num;
        r_beat      <= '0;
        r_acc       <= '0;
        r_expected  <= '0;
        r_received  <= '0;
        r_drain_cnt <= '0;
        r_timeout   <= 1'b0;
        r_extra     <= 1'b0;
      end else begin
        if (w_issue) begin
          r_beat <= r_beat + c_len_one;
          if (r_acc == (r_acc_num - c_acc_one)) begin
            r_acc      <= '0;
            r_expected <= r_expected + c_len_one;
          end else begin
            r_acc <= r_acc + c_acc_one;
          end
        end
        if (w_qv) begin
          r_received <= w_rcv_next;
        end
        if (w_extra_now) begin
          r_extra <= 1'b1;
        end
        if (r_state == DRAIN) begin
          r_drain_cnt <= r_drain_cnt + c_tmo_one;
          if (w_tmo && !w_drain_hit) begin
            r_timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
